// File: rtl/ysyx_22051468_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and PC constants.
package ysyx_22051468_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        HOLD = ST_HOLD
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_22051468_pc_reg.sv
// Register with write enable and an asynchronous active-high reset value.
module ysyx_22051468_pc_reg #(
    parameter int unsigned            WIDTH     = 32,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_22051468_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem
// and hands it to decode; execute redirects override sequential fetch.
module ysyx_22051468_ifu
    import ysyx_22051468_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            idu_valid,
    input  logic            idu_ready,
    output logic [XLEN-1:0] idu_inst,
    output logic [XLEN-1:0] idu_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state;
    ifu_state_e      state_d;
    logic            kill;
    logic            kill_d;
    logic            inst_en;
    logic            redirect_fire;
    logic            hold_fire;
    logic            pc_en;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] inst_q;

    assign redirect_fire = redirect_valid && (state != IDLE);
    assign hold_fire     = (state == HOLD) && idu_ready;
    assign pc_en         = redirect_fire || hold_fire;

    // Next-PC select keyed on {redirect, handshake}; redirect wins.
    always_comb begin
        pc_d = pc;
        case ({redirect_fire, hold_fire})
            2'b10, 2'b11: pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            2'b01:        pc_d = pc + XLEN'(PC_STEP);
            default:      pc_d = pc;
        endcase
    end

    ysyx_22051468_pc_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_d),
        .q   (pc)
    );

    ysyx_22051468_pc_reg #(.WIDTH(XLEN), .RESET_VAL('0)) u_inst (
        .clk (clk),
        .rst (rst),
        .en  (inst_en),
        .d   (imem_resp_data),
        .q   (inst_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_d;
            kill  <= kill_d;
        end
    end

    // A redirect while a request is in flight marks its response for discard.
    always_comb begin
        state_d = state;
        kill_d  = kill;
        inst_en = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    kill_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (kill || redirect_valid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = HOLD;
                        inst_en = 1'b1;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || idu_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req_valid  = (state == REQ);
    assign imem_req_addr   = pc;
    assign imem_resp_ready = (state == WAIT);
    assign idu_valid       = (state == HOLD);
    assign idu_inst        = inst_q;
    assign idu_pc          = pc;

endmodule
